// File: rtl/id_stage_if.sv
// Purpose: bundles the ID stage's pipeline-facing signals: the IF/ID payload,
//          hazard controls, status flags, write-back port, the combinational
//          hazard-unit taps, and the registered ID/EX outputs.
// Modports:
//   slave  - id_stage side (consumes IF/ID, WB, hazards; drives src*/ex_*)
//   master - surrounding pipeline side (the opposite directions)
interface id_stage_if #(
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0] pc_in;
    logic [31:0]       instruction_in;
    logic              freeze;
    logic              flush;
    logic [3:0]        sr;
    logic              wb_wb_en;
    logic [3:0]        wb_dest;
    logic [DATA_W-1:0] wb_value;

    logic [3:0]        src1;
    logic [3:0]        src2;
    logic              two_src;

    logic [DATA_W-1:0] ex_pc;
    logic [DATA_W-1:0] ex_val_rn;
    logic [DATA_W-1:0] ex_val_rm;
    logic [3:0]        ex_cmd;
    logic              ex_wb_en;
    logic              ex_mem_r_en;
    logic              ex_mem_w_en;
    logic              ex_b;
    logic              ex_s;
    logic              ex_imm;
    logic [11:0]       ex_shift_operand;
    logic [23:0]       ex_imm24;
    logic [3:0]        ex_dest;

    modport slave (
        input  pc_in, instruction_in, freeze, flush, sr,
               wb_wb_en, wb_dest, wb_value,
        output src1, src2, two_src,
               ex_pc, ex_val_rn, ex_val_rm, ex_cmd,
               ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_imm,
               ex_shift_operand, ex_imm24, ex_dest
    );

    modport master (
        output pc_in, instruction_in, freeze, flush, sr,
               wb_wb_en, wb_dest, wb_value,
        input  src1, src2, two_src,
               ex_pc, ex_val_rn, ex_val_rm, ex_cmd,
               ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_imm,
               ex_shift_operand, ex_imm24, ex_dest
    );
endinterface

// File: rtl/id_stage.sv
// Purpose: instruction decode stage of the 5-stage ARM-subset pipeline plus
//          the ID/EX pipeline register. Holds R0..R14, decodes controls,
//          evaluates the condition field against sr, and registers the
//          operands and controls for EX.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-low reset
//   bus  - id_stage_if.slave: IF/ID inputs, hazards, write-back, src taps
//          (combinational) and the registered ex_* outputs
module id_stage #(
    parameter int unsigned REG_INIT_INDEX = 1,
    parameter int unsigned DATA_W         = 32
) (
    input  logic       clk,
    input  logic       rst,
    id_stage_if.slave  bus
);
    localparam int unsigned NUM_REGS = 15;
    localparam logic [3:0]  PC_IDX   = 4'd15;

    // Instruction fields
    logic [3:0]  cond;
    logic [1:0]  mode;
    logic        i_bit;
    logic [3:0]  opcode;
    logic        s_bit;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic        is_str;

    assign cond   = bus.instruction_in[31:28];
    assign mode   = bus.instruction_in[27:26];
    assign i_bit  = bus.instruction_in[25];
    assign opcode = bus.instruction_in[24:21];
    assign s_bit  = bus.instruction_in[20];
    assign rn     = bus.instruction_in[19:16];
    assign rd     = bus.instruction_in[15:12];
    assign is_str = (mode == 2'b01) && !s_bit;

    // Hazard-unit taps: STR reads Rd as its second source (the store data)
    assign bus.src1    = rn;
    assign bus.src2    = is_str ? rd : bus.instruction_in[3:0];
    assign bus.two_src = ((mode == 2'b00) && !i_bit) || is_str;

    // Register file R0..R14; index 15 is the pc and is never stored
    logic [DATA_W-1:0] rf [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                rf[i] <= (REG_INIT_INDEX != 0) ? DATA_W'(i) : '0;
            end
        end else if (bus.wb_wb_en && (bus.wb_dest != PC_IDX)) begin
            rf[bus.wb_dest] <= bus.wb_value;
        end
    end

    // Reads bypass a same-cycle write-back so WB->ID needs no stall
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;

    assign val_rn = (rn == PC_IDX) ? bus.pc_in :
                    (bus.wb_wb_en && (bus.wb_dest == rn)) ? bus.wb_value : rf[rn];
    assign val_rm = (bus.src2 == PC_IDX) ? bus.pc_in :
                    (bus.wb_wb_en && (bus.wb_dest == bus.src2)) ? bus.wb_value : rf[bus.src2];

    // Condition evaluation on {N,Z,C,V}
    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_ok;

    assign {flag_n, flag_z, flag_c, flag_v} = bus.sr;

    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'b0000: cond_ok = flag_z;
            4'b0001: cond_ok = !flag_z;
            4'b0010: cond_ok = flag_c;
            4'b0011: cond_ok = !flag_c;
            4'b0100: cond_ok = flag_n;
            4'b0101: cond_ok = !flag_n;
            4'b0110: cond_ok = flag_v;
            4'b0111: cond_ok = !flag_v;
            4'b1000: cond_ok = flag_c && !flag_z;
            4'b1001: cond_ok = !flag_c || flag_z;
            4'b1010: cond_ok = (flag_n == flag_v);
            4'b1011: cond_ok = (flag_n != flag_v);
            4'b1100: cond_ok = !flag_z && (flag_n == flag_v);
            4'b1101: cond_ok = flag_z || (flag_n != flag_v);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // Control decode; a failed condition kills side effects but keeps cmd
    logic [3:0] cmd;
    logic       wb_en, mem_r_en, mem_w_en, b, s;

    always_comb begin
        cmd      = 4'b0000;
        wb_en    = 1'b0;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        b        = 1'b0;
        s        = 1'b0;
        case (mode)
            2'b00: begin
                wb_en = 1'b1;
                s     = s_bit;
                case (opcode)
                    4'b1101: cmd = 4'b0001;
                    4'b1111: cmd = 4'b1001;
                    4'b0100: cmd = 4'b0010;
                    4'b0101: cmd = 4'b0011;
                    4'b0010: cmd = 4'b0100;
                    4'b0110: cmd = 4'b0101;
                    4'b0000: cmd = 4'b0110;
                    4'b1100: cmd = 4'b0111;
                    4'b0001: cmd = 4'b1000;
                    4'b1010: begin cmd = 4'b0100; wb_en = 1'b0; end
                    4'b1000: begin cmd = 4'b0110; wb_en = 1'b0; end
                    default: begin wb_en = 1'b0; s = 1'b0; end
                endcase
            end
            2'b01: begin
                cmd = 4'b0010;
                if (s_bit) begin
                    mem_r_en = 1'b1;
                    wb_en    = 1'b1;
                end else begin
                    mem_w_en = 1'b1;
                end
            end
            2'b10: b = 1'b1;
            default: ;
        endcase
        if (!cond_ok) begin
            wb_en    = 1'b0;
            mem_r_en = 1'b0;
            mem_w_en = 1'b0;
            b        = 1'b0;
            s        = 1'b0;
        end
    end

    // ID/EX register; freeze/flush insert a bubble by clearing cmd and controls
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.ex_pc            <= '0;
            bus.ex_val_rn        <= '0;
            bus.ex_val_rm        <= '0;
            bus.ex_cmd           <= '0;
            bus.ex_wb_en         <= 1'b0;
            bus.ex_mem_r_en      <= 1'b0;
            bus.ex_mem_w_en      <= 1'b0;
            bus.ex_b             <= 1'b0;
            bus.ex_s             <= 1'b0;
            bus.ex_imm           <= 1'b0;
            bus.ex_shift_operand <= '0;
            bus.ex_imm24         <= '0;
            bus.ex_dest          <= '0;
        end else begin
            bus.ex_pc            <= bus.pc_in;
            bus.ex_val_rn        <= val_rn;
            bus.ex_val_rm        <= val_rm;
            bus.ex_imm           <= i_bit;
            bus.ex_shift_operand <= bus.instruction_in[11:0];
            bus.ex_imm24         <= bus.instruction_in[23:0];
            bus.ex_dest          <= rd;
            if (bus.freeze || bus.flush) begin
                bus.ex_cmd      <= '0;
                bus.ex_wb_en    <= 1'b0;
                bus.ex_mem_r_en <= 1'b0;
                bus.ex_mem_w_en <= 1'b0;
                bus.ex_b        <= 1'b0;
                bus.ex_s        <= 1'b0;
            end else begin
                bus.ex_cmd      <= cmd;
                bus.ex_wb_en    <= wb_en;
                bus.ex_mem_r_en <= mem_r_en;
                bus.ex_mem_w_en <= mem_w_en;
                bus.ex_b        <= b;
                bus.ex_s        <= s;
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Purpose: directed self-checking bench for id_stage with REG_INIT_INDEX=1.
module tb_id_stage;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    id_stage_if bus ();

    id_stage #(.REG_INIT_INDEX(1), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [3:0] sr);
        bus.instruction_in = instr;
        bus.pc_in          = pc;
        bus.sr             = sr;
    endtask

    task automatic test_reset();
        logic [145:0] all_ex;
        rst = 1'b0;
        drive(32'hE083_0003, 32'h55, 4'b0000);
        bus.wb_wb_en = 1'b1; bus.wb_dest = 4'd4; bus.wb_value = 32'h999;
        tick();
        tick();
        bus.wb_wb_en = 1'b0;
        all_ex = {bus.ex_pc, bus.ex_val_rn, bus.ex_val_rm, bus.ex_cmd, bus.ex_wb_en,
                  bus.ex_mem_r_en, bus.ex_mem_w_en, bus.ex_b, bus.ex_s, bus.ex_imm,
                  bus.ex_shift_operand, bus.ex_imm24, bus.ex_dest};
        checks++; if (all_ex !== '0) begin errors++; $display("FAIL reset_ex_zero got=%h exp=0", all_ex); end
        rst = 1'b1;
        drive(32'hE1A0_1002, 32'h4, 4'b0000);
        tick();
        checks++; if (bus.ex_cmd !== 4'b0001) begin errors++; $display("FAIL mov_cmd got=%b exp=0001", bus.ex_cmd); end
        checks++; if (bus.ex_wb_en !== 1'b1) begin errors++; $display("FAIL mov_wb_en got=%b exp=1", bus.ex_wb_en); end
        checks++; if (bus.ex_dest !== 4'd1) begin errors++; $display("FAIL mov_dest got=%0d exp=1", bus.ex_dest); end
        checks++; if (bus.ex_val_rm !== 32'd2) begin errors++; $display("FAIL mov_val_rm got=%h exp=2", bus.ex_val_rm); end
        checks++; if (bus.ex_imm !== 1'b0) begin errors++; $display("FAIL mov_imm got=%b exp=0", bus.ex_imm); end
        checks++; if (bus.ex_shift_operand !== 12'h002) begin errors++; $display("FAIL mov_shop got=%h exp=002", bus.ex_shift_operand); end
    endtask

    // Reset must have beaten the simultaneous write to R4
    task automatic test_reset_over_wb();
        drive(32'hE084_0004, 32'h8, 4'b0000);
        tick();
        checks++; if (bus.ex_val_rn !== 32'd4) begin errors++; $display("FAIL reset_over_wb got=%h exp=4", bus.ex_val_rn); end
    endtask

    task automatic test_write_through();
        drive(32'hE083_0003, 32'h8, 4'b0000);
        bus.wb_wb_en = 1'b1; bus.wb_dest = 4'd3; bus.wb_value = 32'hDEAD_BEEF;
        tick();
        bus.wb_wb_en = 1'b0;
        checks++; if (bus.ex_val_rn !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wt_val_rn got=%h exp=deadbeef", bus.ex_val_rn); end
        checks++; if (bus.ex_val_rm !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wt_val_rm got=%h exp=deadbeef", bus.ex_val_rm); end
        checks++; if (bus.ex_cmd !== 4'b0010) begin errors++; $display("FAIL wt_cmd got=%b exp=0010", bus.ex_cmd); end
    endtask

    task automatic test_condition();
        logic [3:0] conds [10];
        logic [3:0] srs   [10];
        logic       exps  [10];
        conds = '{4'h1, 4'h1, 4'h8, 4'h8, 4'hA, 4'hB, 4'hC, 4'hC, 4'hD, 4'hF};
        srs   = '{4'b0100, 4'b0000, 4'b0010, 4'b0110, 4'b1001, 4'b1000, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
        exps  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 10; k++) begin
            drive({conds[k], 28'h083_0003}, 32'h8, srs[k]);
            tick();
            checks++; if (bus.ex_wb_en !== exps[k]) begin errors++; $display("FAIL cond_%0d wb_en got=%b exp=%b", k, bus.ex_wb_en, exps[k]); end
            checks++; if (bus.ex_cmd !== 4'b0010) begin errors++; $display("FAIL cond_%0d cmd got=%b exp=0010", k, bus.ex_cmd); end
        end
        // R3 holds the earlier write-back
        checks++; if (bus.ex_val_rn !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rf_persist got=%h exp=deadbeef", bus.ex_val_rn); end
        drive(32'h0093_0003, 32'h8, 4'b0100);
        tick();
        checks++; if (bus.ex_s !== 1'b1) begin errors++; $display("FAIL adds_s got=%b exp=1", bus.ex_s); end
        drive(32'h0093_0003, 32'h8, 4'b0000);
        tick();
        checks++; if (bus.ex_s !== 1'b0) begin errors++; $display("FAIL adds_s_condfail got=%b exp=0", bus.ex_s); end
        drive(32'hE153_0003, 32'h8, 4'b0000);
        tick();
        checks++; if ({bus.ex_cmd, bus.ex_wb_en, bus.ex_s} !== 6'b0100_0_1) begin errors++; $display("FAIL cmp got=%b exp=010001", {bus.ex_cmd, bus.ex_wb_en, bus.ex_s}); end
    endtask

    task automatic test_memory();
        drive(32'hE591_2004, 32'h8, 4'b0000);
        tick();
        checks++; if ({bus.ex_mem_r_en, bus.ex_mem_w_en, bus.ex_wb_en} !== 3'b101) begin errors++; $display("FAIL ldr_ctl got=%b exp=101", {bus.ex_mem_r_en, bus.ex_mem_w_en, bus.ex_wb_en}); end
        checks++; if (bus.ex_cmd !== 4'b0010) begin errors++; $display("FAIL ldr_cmd got=%b exp=0010", bus.ex_cmd); end
        checks++; if (bus.ex_dest !== 4'd2) begin errors++; $display("FAIL ldr_dest got=%0d exp=2", bus.ex_dest); end
        checks++; if (bus.ex_val_rn !== 32'd1) begin errors++; $display("FAIL ldr_val_rn got=%h exp=1", bus.ex_val_rn); end
        drive(32'hE581_2004, 32'h8, 4'b0000);
        #1;
        checks++; if (bus.src2 !== 4'd2) begin errors++; $display("FAIL str_src2 got=%0d exp=2", bus.src2); end
        checks++; if (bus.two_src !== 1'b1) begin errors++; $display("FAIL str_two_src got=%b exp=1", bus.two_src); end
        checks++; if (bus.src1 !== 4'd1) begin errors++; $display("FAIL str_src1 got=%0d exp=1", bus.src1); end
        tick();
        checks++; if ({bus.ex_mem_r_en, bus.ex_mem_w_en, bus.ex_wb_en} !== 3'b010) begin errors++; $display("FAIL str_ctl got=%b exp=010", {bus.ex_mem_r_en, bus.ex_mem_w_en, bus.ex_wb_en}); end
        checks++; if (bus.ex_val_rm !== 32'd2) begin errors++; $display("FAIL str_val_rm got=%h exp=2", bus.ex_val_rm); end
        drive(32'hE3A0_1005, 32'h8, 4'b0000);
        #1;
        checks++; if (bus.two_src !== 1'b0) begin errors++; $display("FAIL movimm_two_src got=%b exp=0", bus.two_src); end
    endtask

    task automatic test_bubble();
        logic [1:0] ff [3];
        ff = '{2'b10, 2'b01, 2'b11};
        for (int k = 0; k < 3; k++) begin
            drive(32'hE083_0003, 32'h8, 4'b0000);
            {bus.freeze, bus.flush} = ff[k];
            // Write-back still lands during a bubble
            bus.wb_wb_en = 1'b1; bus.wb_dest = 4'd5; bus.wb_value = 32'hA5A5_0000 + 32'(k);
            tick();
            bus.wb_wb_en = 1'b0;
            checks++; if ({bus.ex_cmd, bus.ex_wb_en, bus.ex_mem_r_en, bus.ex_mem_w_en, bus.ex_b, bus.ex_s} !== 9'b0)
                begin errors++; $display("FAIL bubble_%0d got=%b exp=0", k, {bus.ex_cmd, bus.ex_wb_en, bus.ex_mem_r_en, bus.ex_mem_w_en, bus.ex_b, bus.ex_s}); end
        end
        {bus.freeze, bus.flush} = 2'b00;
        drive(32'hE085_0005, 32'h8, 4'b0000);
        tick();
        checks++; if ({bus.ex_cmd, bus.ex_wb_en} !== 5'b0010_1) begin errors++; $display("FAIL resume got=%b exp=00101", {bus.ex_cmd, bus.ex_wb_en}); end
        checks++; if (bus.ex_val_rn !== 32'hA5A5_0002) begin errors++; $display("FAIL wb_during_bubble got=%h exp=a5a50002", bus.ex_val_rn); end
    endtask

    task automatic test_branch_r15();
        drive(32'hEA00_0005, 32'h10, 4'b0000);
        tick();
        checks++; if (bus.ex_b !== 1'b1) begin errors++; $display("FAIL br_b got=%b exp=1", bus.ex_b); end
        checks++; if (bus.ex_imm24 !== 24'h000005) begin errors++; $display("FAIL br_imm24 got=%h exp=000005", bus.ex_imm24); end
        checks++; if (bus.ex_pc !== 32'h10) begin errors++; $display("FAIL br_pc got=%h exp=10", bus.ex_pc); end
        checks++; if ({bus.ex_cmd, bus.ex_wb_en} !== 5'b0) begin errors++; $display("FAIL br_ctl got=%b exp=0", {bus.ex_cmd, bus.ex_wb_en}); end
        drive(32'h0A00_0005, 32'h10, 4'b0000);
        tick();
        checks++; if (bus.ex_b !== 1'b0) begin errors++; $display("FAIL br_condfail got=%b exp=0", bus.ex_b); end
        // R15 reads pc_in even while write-back targets index 15
        drive(32'hE08F_000F, 32'h44, 4'b0000);
        bus.wb_wb_en = 1'b1; bus.wb_dest = 4'd15; bus.wb_value = 32'h1234_5678;
        tick();
        bus.wb_wb_en = 1'b0;
        checks++; if (bus.ex_val_rn !== 32'h44) begin errors++; $display("FAIL r15_rn got=%h exp=44", bus.ex_val_rn); end
        checks++; if (bus.ex_val_rm !== 32'h44) begin errors++; $display("FAIL r15_rm got=%h exp=44", bus.ex_val_rm); end
        drive(32'hE08E_0000, 32'h48, 4'b0000);
        tick();
        checks++; if (bus.ex_val_rn !== 32'd14) begin errors++; $display("FAIL r14_intact got=%h exp=e", bus.ex_val_rn); end
        checks++; if (bus.ex_val_rm !== 32'd0) begin errors++; $display("FAIL r0_intact got=%h exp=0", bus.ex_val_rm); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        bus.freeze = 1'b0;
        bus.flush = 1'b0;
        bus.wb_wb_en = 1'b0;
        bus.wb_dest = 4'd0;
        bus.wb_value = 32'd0;
        drive(32'd0, 32'd0, 4'd0);
        test_reset();
        test_reset_over_wb();
        test_write_through();
        test_condition();
        test_memory();
        test_bubble();
        test_branch_r15();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Instruction Decode stage plus the ID/EX pipeline register of the 5-stage ARM-subset pipeline.
- Takes the IF/ID-registered pc and instruction from IF_STAGE.
- Holds the 15-entry general register file, which write-back writes.
- Decodes control signals, evaluates the condition field against the status register, and drives registered operands/controls to EX.
- Exposes combinational source-register info to the hazard unit, which in turn drives freeze into IF_STAGE.

Parameters:
REG_INIT_INDEX, 1, 1: register Ri resets to value i; 0: all registers reset to 0.
DATA_W, 32, datapath width; only 32 is supported.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous reset, active-low; sampled on rising clk.
pc_in  in  32  pc from the IF/ID register (already pc+1).
instruction_in  in  32  instruction from the IF/ID register.
freeze  in  1  hazard stall; ID/EX loads a bubble.
flush  in  1  Branch_Taken from EX; ID/EX loads a bubble.
sr  in  4  status flags {N,Z,C,V}.
wb_wb_en  in  1  write-back enable.
wb_dest  in  4  write-back register index.
wb_value  in  32  write-back data.
src1  out  4  Rn field, combinational.
src2  out  4  Rm (bits[3:0]) for register operands, else Rd for STR; combinational.
two_src  out  1  combinational: (I==0 data-processing) or STR.
ex_pc, ex_val_rn, ex_val_rm  out  32  registered.
ex_cmd  out  4  registered.
ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_imm  out  1  registered.
ex_shift_operand  out  12  registered.
ex_imm24  out  24  registered.
ex_dest  out  4  registered.

Behaviour:
Instruction fields:
- cond[31:28], mode[27:26], I[25], opcode[24:21], S/L[20], Rn[19:16], Rd[15:12], shift_operand[11:0], imm24[23:0].

Decode by mode:
- mode 00, data-processing. EX_CMD map:
  - MOV 1101->0001, MVN 1111->1001
  - ADD 0100->0010, ADC 0101->0011
  - SUB 0010->0100, SBC 0110->0101
  - AND 0000->0110, ORR 1100->0111, EOR 0001->1000
  - CMP 1010->0100, TST 1000->0110
- wb_en=1 for all data-processing opcodes except CMP and TST.
- Any other opcode: cmd=0000 and all controls 0.
- mode 01, memory: cmd=0010. L=1 is LDR (mem_r_en=1, wb_en=1). L=0 is STR (mem_w_en=1).
- mode 10, branch: b=1, all other controls 0.
- mode 11: all controls 0.
- s output = bit20 for data-processing only, else 0.

Condition check, combinational on sr:
- EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL per ARM.
- cond 1111 evaluates false.
- Condition false: wb_en, mem_r_en, mem_w_en, b and s are all forced to 0.

Register file:
- R0..R14, 32-bit. Written on rising clk when wb_wb_en=1 and wb_dest!=15; writes to index 15 are ignored.
- Reads are combinational with write-through: if wb_wb_en and wb_dest equals the read index (not 15), the read returns wb_value in the same cycle.
- Read index 15 returns pc_in.
- val_rn reads Rn. val_rm reads src2.

ID/EX register, on each rising clk, in priority order:
1. rst==0: all ex_* outputs become 0. Registers reset to i (REG_INIT_INDEX=1) or 0.
2. flush==1 or freeze==1: control bits (wb_en, mem_r_en, mem_w_en, b, s) and ex_cmd become 0. Data fields still load, but their values are don't-care.
3. Otherwise: load all decoded values.

Timing, hazards and reset:
- Latency is 1 cycle from instruction_in to ex_* outputs.
- The register-file write is independent of freeze and flush.
- Reset asserted mid-operation overrides a simultaneous write-back.
- flush and freeze together: bubble (single behaviour).

Test Plan:
- Reset then release: all ex_* outputs are 0; with REG_INIT_INDEX=1, instruction 0xE1A0_1002 (MOV R1,R2) yields, one cycle later, ex_cmd=0001, ex_wb_en=1, ex_dest=1, ex_val_rm=2, ex_imm=0.
- Write-through: wb_wb_en=1, wb_dest=3, wb_value=0xDEAD_BEEF alongside instruction ADD R0,R3,R3 (0xE083_0003) -> next cycle ex_val_rn=ex_val_rm=0xDEAD_BEEF, ex_cmd=0010.
- Condition fail: sr=0100 (Z=1) with NE ADD (0x1083_0003) -> ex_wb_en=0 and ex_cmd=0010. With sr=0000 the same instruction gives ex_wb_en=1.
- Memory ops: LDR 0xE591_2004 -> mem_r_en=1, wb_en=1, cmd=0010, dest=2. STR 0xE581_2004 -> mem_w_en=1, wb_en=0, src2=2, two_src=1.
- Bubble: valid ADD presented with freeze=1 -> all controls 0 next cycle. Same with flush=1. Deassert either -> normal decode resumes on the next edge.
- Branch/R15 edge cases: branch 0xEA00_0005 with pc_in=0x10 -> ex_b=1, ex_imm24=0x000005, ex_pc=0x10. A read of R15 returns pc_in. Write-back to index 15 leaves the register file unchanged.
